// File: rtl/updi_phy_arbiter.sv
// updi_phy_arbiter
// Shares a single updi_phy between two requesters (for example the UPDI
// programmer and a debug/monitor engine). The current owner's TX FIFO write
// port, RX FIFO read port and double-break handshake are routed to the PHY.
// Once an owner lets go, stale RX bytes are drained so the next owner starts
// with an empty RX FIFO.
//
// Optional feature: define UPDI_ARB_WATCHDOG_EN to build the inactivity
// watchdog. It forcibly releases an idle owner after WATCHDOG_CLKS clocks,
// pulses revoke[owner] and locks that requester out until it drops req.
// Without the macro, revoke is tied low and an owner keeps the PHY until it
// drops req.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req[1:0]                 level-held ownership requests
//   gnt[1:0]                 one-hot-or-zero grant (registered)
//   revoke[1:0]              one-cycle watchdog release pulse
//   m_tx_* / m_rx_* / m_db_* per-requester FIFO and double-break ports
//   uart_tx_fifo_*, uart_rx_fifo_*, phy_error, double_break_*  PHY side
module updi_phy_arbiter #(
    parameter int WATCHDOG_CLKS = 50000000,
    parameter int FLUSH_MAX     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [1:0]  revoke,
    input  logic [15:0] m_tx_data,
    input  logic [1:0]  m_tx_wr_en,
    output logic [1:0]  m_tx_full,
    output logic [7:0]  m_rx_data,
    input  logic [1:0]  m_rx_rd_en,
    output logic [1:0]  m_rx_empty,
    output logic [1:0]  m_rx_error,
    input  logic [1:0]  m_db_start,
    output logic [1:0]  m_db_busy,
    output logic [1:0]  m_db_done,
    output logic [7:0]  uart_tx_fifo_data_in,
    output logic        uart_tx_fifo_wr_en,
    input  logic        uart_tx_fifo_full,
    input  logic [7:0]  uart_rx_fifo_data_out,
    output logic        uart_rx_fifo_rd_en,
    input  logic        uart_rx_fifo_empty,
    input  logic        phy_error,
    output logic        double_break_start,
    input  logic        double_break_busy,
    input  logic        double_break_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int FC_W = $clog2(FLUSH_MAX + 1);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_MAX - 1);

    state_t          state_q;
    logic            owner_q;
    logic            lastOwner_q;
    logic [1:0]      gnt_q;
    logic [FC_W-1:0] flushCnt_q;

    logic [1:0]      eligible;
    logic            pick;
    logic            releaseNow;
    logic            revokeNow;

    // A double break in flight is never aborted, so release waits for busy to fall.
    assign releaseNow = (state_q == GRANT) && !req[owner_q] && !double_break_busy;

    // Round-robin on a tie: the requester that did not own the PHY last wins.
    assign pick = (eligible == 2'b11) ? ~lastOwner_q : eligible[1];

`ifdef UPDI_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CLKS + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CLKS - 1);

    logic [WD_W-1:0] wdCnt_q;
    logic [WD_W-1:0] wdCnt_d;
    logic [1:0]      lock_q;
    logic [1:0]      revoke_q;
    logic            ownerActive;

    assign ownerActive = m_tx_wr_en[owner_q] | m_rx_rd_en[owner_q] |
                         m_db_start[owner_q] | double_break_busy;

    // A normal release in the same cycle as expiry wins; no revoke then.
    assign revokeNow = (state_q == GRANT) && !releaseNow && !ownerActive &&
                       (wdCnt_q == WD_LAST);

    // Idle counter: cleared outside GRANT and on any owner activity, saturating.
    always_comb begin
        wdCnt_d = wdCnt_q;
        if ((state_q != GRANT) || ownerActive) begin
            wdCnt_d = '0;
        end else if (wdCnt_q != '1) begin
            wdCnt_d = wdCnt_q + WD_W'(1);
        end
    end

    // A revoked requester stays locked out until it has dropped req once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt_q  <= '0;
            lock_q   <= 2'b00;
            revoke_q <= 2'b00;
        end else begin
            wdCnt_q  <= wdCnt_d;
            lock_q   <= lock_q & req;
            revoke_q <= 2'b00;
            if (revokeNow) begin
                lock_q[owner_q]   <= 1'b1;
                revoke_q[owner_q] <= 1'b1;
            end
        end
    end

    assign eligible = req & ~lock_q;
    assign revoke   = revoke_q;
`else
    assign revokeNow = 1'b0;
    assign eligible  = req;
    // The parameter stays in the interface so both builds instantiate alike.
    assign revoke    = 2'b00 & {2{WATCHDOG_CLKS > 0}};
`endif

    // Ownership FSM; gnt is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastOwner_q <= 1'b1;
            gnt_q       <= 2'b00;
            flushCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    flushCnt_q <= '0;
                    if (|eligible) begin
                        owner_q <= pick;
                        gnt_q   <= pick ? 2'b10 : 2'b01;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (releaseNow || revokeNow) begin
                        gnt_q       <= 2'b00;
                        lastOwner_q <= owner_q;
                        flushCnt_q  <= '0;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (uart_rx_fifo_empty) begin
                        state_q <= IDLE;
                    end else begin
                        flushCnt_q <= flushCnt_q + FC_W'(1);
                        if (flushCnt_q == FLUSH_LAST) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt = gnt_q;

    // Routing: only the owner reaches the PHY; the non-owner sees full/empty
    // and no status. During FLUSH the arbiter itself drains the RX FIFO.
    always_comb begin
        uart_tx_fifo_data_in = 8'h00;
        uart_tx_fifo_wr_en   = 1'b0;
        uart_rx_fifo_rd_en   = 1'b0;
        double_break_start   = 1'b0;
        m_tx_full            = 2'b11;
        m_rx_empty           = 2'b11;
        m_rx_error           = 2'b00;
        m_db_busy            = 2'b00;
        m_db_done            = 2'b00;
        m_rx_data            = 8'h00;
        if (state_q == GRANT) begin
            uart_tx_fifo_data_in = owner_q ? m_tx_data[15:8] : m_tx_data[7:0];
            uart_tx_fifo_wr_en   = m_tx_wr_en[owner_q];
            uart_rx_fifo_rd_en   = m_rx_rd_en[owner_q];
            double_break_start   = m_db_start[owner_q];
            m_tx_full[owner_q]   = uart_tx_fifo_full;
            m_rx_empty[owner_q]  = uart_rx_fifo_empty;
            m_rx_error[owner_q]  = phy_error;
            m_db_busy[owner_q]   = double_break_busy;
            m_db_done[owner_q]   = double_break_done;
            m_rx_data            = uart_rx_fifo_data_out;
        end else if (state_q == FLUSH) begin
            uart_rx_fifo_rd_en = ~uart_rx_fifo_empty;
        end
    end

endmodule

// File: tb/tb_updi_phy_arbiter.sv
// tb_updi_phy_arbiter
// Self-checking bench for updi_phy_arbiter. A behavioural ownership model
// (owner as an integer, flush and idle counters as plain ints) and a queue-based
// PHY RX FIFO predict every output; a compare process checks the DUT on each
// falling edge. Directed scenarios pin the model with literal expectations,
// then a randomized phase exercises arbitration, flushing and the watchdog.
module tb_updi_phy_arbiter;

    localparam int WD = 20;
    localparam int FM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  revoke;
    logic [15:0] m_tx_data;
    logic [1:0]  m_tx_wr_en;
    logic [1:0]  m_tx_full;
    logic [7:0]  m_rx_data;
    logic [1:0]  m_rx_rd_en;
    logic [1:0]  m_rx_empty;
    logic [1:0]  m_rx_error;
    logic [1:0]  m_db_start;
    logic [1:0]  m_db_busy;
    logic [1:0]  m_db_done;
    logic [7:0]  uart_tx_fifo_data_in;
    logic        uart_tx_fifo_wr_en;
    logic        uart_tx_fifo_full;
    logic [7:0]  uart_rx_fifo_data_out;
    logic        uart_rx_fifo_rd_en;
    logic        uart_rx_fifo_empty;
    logic        phy_error;
    logic        double_break_start;
    logic        double_break_busy;
    logic        double_break_done;

    int testsRun    = 0;
    int testsFailed = 0;

    // PHY RX FIFO contents and the arbiter read strobe seen last falling edge.
    logic [7:0] rxq[$];
    logic       rdEnSeen = 1'b0;

    // Ownership model: -1 means nobody owns the PHY.
    int         mOwner;
    bit         mFlush;
    int         mFlushCnt;
    int         mLast;
    logic [1:0] mLock;
    logic [1:0] mRevoke;
`ifdef UPDI_ARB_WATCHDOG_EN
    int         mIdle;
`endif

    always #5 clk = ~clk;

    updi_phy_arbiter #(
        .WATCHDOG_CLKS(WD),
        .FLUSH_MAX(FM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .revoke(revoke),
        .m_tx_data(m_tx_data),
        .m_tx_wr_en(m_tx_wr_en),
        .m_tx_full(m_tx_full),
        .m_rx_data(m_rx_data),
        .m_rx_rd_en(m_rx_rd_en),
        .m_rx_empty(m_rx_empty),
        .m_rx_error(m_rx_error),
        .m_db_start(m_db_start),
        .m_db_busy(m_db_busy),
        .m_db_done(m_db_done),
        .uart_tx_fifo_data_in(uart_tx_fifo_data_in),
        .uart_tx_fifo_wr_en(uart_tx_fifo_wr_en),
        .uart_tx_fifo_full(uart_tx_fifo_full),
        .uart_rx_fifo_data_out(uart_rx_fifo_data_out),
        .uart_rx_fifo_rd_en(uart_rx_fifo_rd_en),
        .uart_rx_fifo_empty(uart_rx_fifo_empty),
        .phy_error(phy_error),
        .double_break_start(double_break_start),
        .double_break_busy(double_break_busy),
        .double_break_done(double_break_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refreshPhy();
        uart_rx_fifo_empty    = (rxq.size() == 0);
        uart_rx_fifo_data_out = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    // Advance one clock; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        refreshPhy();
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d, input logic [1:0] wr,
                                 input logic [1:0] rd, input logic [1:0] db, input logic busy);
        req               = r;
        m_tx_data         = d;
        m_tx_wr_en        = wr;
        m_rx_rd_en        = rd;
        m_db_start        = db;
        double_break_busy = busy;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        uart_tx_fifo_full = 1'b0;
        phy_error         = 1'b0;
        double_break_done = 1'b0;
        rxq.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic waitGnt(input string name, input logic [1:0] want, input int maxCycles);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            tick();
            @(negedge clk);
            if (gnt == want) seen = 1'b1;
        end
        checkOutput(name, {63'd0, seen}, 64'd1);
    endtask

    // Model update on each rising edge, using the inputs the DUT samples.
    always @(posedge clk or posedge rst) begin : modelUpdate
        int o;
        logic [1:0] eff;
`ifdef UPDI_ARB_WATCHDOG_EN
        logic act;
`endif
        if (rst) begin
            mOwner    = -1;
            mFlush    = 1'b0;
            mFlushCnt = 0;
            mLast     = 1;
            mLock     = 2'b00;
            mRevoke   = 2'b00;
`ifdef UPDI_ARB_WATCHDOG_EN
            mIdle     = 0;
`endif
            rxq.delete();
        end else begin
            mRevoke = 2'b00;
            mLock   = mLock & req;
            if (mFlush) begin
                if (uart_rx_fifo_empty) begin
                    mFlush = 1'b0;
                end else begin
                    mFlushCnt++;
                    if (mFlushCnt >= FM) mFlush = 1'b0;
                end
            end else if (mOwner < 0) begin
                eff = req & ~mLock;
                if (eff == 2'b11) o = (mLast == 0) ? 1 : 0;
                else if (eff[0]) o = 0;
                else if (eff[1]) o = 1;
                else o = -1;
                if (o >= 0) begin
                    mOwner = o;
`ifdef UPDI_ARB_WATCHDOG_EN
                    mIdle  = 0;
`endif
                end
            end else begin
                o = mOwner;
                if (!req[o] && !double_break_busy) begin
                    mLast     = o;
                    mOwner    = -1;
                    mFlush    = 1'b1;
                    mFlushCnt = 0;
                end
`ifdef UPDI_ARB_WATCHDOG_EN
                else begin
                    act = m_tx_wr_en[o] | m_rx_rd_en[o] | m_db_start[o] | double_break_busy;
                    if (act) begin
                        mIdle = 0;
                    end else begin
                        mIdle++;
                        if (mIdle >= WD) begin
                            mRevoke[o] = 1'b1;
                            mLock[o]   = 1'b1;
                            mLast      = o;
                            mOwner     = -1;
                            mFlush     = 1'b1;
                            mFlushCnt  = 0;
                        end
                    end
                end
`endif
            end
            if (rdEnSeen && rxq.size() > 0) void'(rxq.pop_front());
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin : compareProc
        logic [16:0] eCtrl;
        logic [16:0] aCtrl;
        logic [1:0]  eGnt, eFull, eEmpty, eErr, eBusy, eDone;
        logic        eWr, eRd, eDb;
        int o;
        rdEnSeen = uart_rx_fifo_rd_en;
        if (!rst) begin
            eGnt = 2'b00; eFull = 2'b11; eEmpty = 2'b11;
            eErr = 2'b00; eBusy = 2'b00; eDone = 2'b00;
            eWr = 1'b0; eRd = 1'b0; eDb = 1'b0;
            if (mOwner >= 0) begin
                o = mOwner;
                eGnt[o]   = 1'b1;
                eWr       = m_tx_wr_en[o];
                eRd       = m_rx_rd_en[o];
                eDb       = m_db_start[o];
                eFull[o]  = uart_tx_fifo_full;
                eEmpty[o] = uart_rx_fifo_empty;
                eErr[o]   = phy_error;
                eBusy[o]  = double_break_busy;
                eDone[o]  = double_break_done;
                checkOutput("cycle_data", {48'd0, uart_tx_fifo_data_in, m_rx_data},
                            {48'd0, m_tx_data[8*o +: 8], uart_rx_fifo_data_out});
            end else if (mFlush) begin
                eRd = !uart_rx_fifo_empty;
            end
            eCtrl = {eGnt, mRevoke, eFull, eEmpty, eErr, eBusy, eDone, eWr, eRd, eDb};
            aCtrl = {gnt, revoke, m_tx_full, m_rx_empty, m_rx_error, m_db_busy, m_db_done,
                     uart_tx_fifo_wr_en, uart_rx_fifo_rd_en, double_break_start};
            checkOutput("cycle_ctrl", {47'd0, aCtrl}, {47'd0, eCtrl});
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, limit 1000000 ns");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt;
        bit leak;
        bit bad;
        int firstRev;
        doReset();

        // Reset state
        @(negedge clk);
        checkOutput("rst_gnt", {62'd0, gnt}, 64'd0);
        checkOutput("rst_full_empty", {60'd0, m_tx_full, m_rx_empty}, 64'hF);
        checkOutput("rst_strobes", {61'd0, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en, double_break_start}, 64'd0);

        // 1: single request, owner write routed, other blocked
        tick();
        applyStimulus(2'b01, 16'hAA55, 2'b11, 2'b00, 2'b00, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("t1_gnt", {62'd0, gnt}, 64'h1);
        checkOutput("t1_txdata", {56'd0, uart_tx_fifo_data_in}, 64'h55);
        checkOutput("t1_wren", {63'd0, uart_tx_fifo_wr_en}, 64'h1);
        checkOutput("t1_full1", {63'd0, m_tx_full[1]}, 64'h1);

        // 2: tie after reset goes to requester 0, then hands over to 1
        doReset();
        applyStimulus(2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("t2_tie", {62'd0, gnt}, 64'h1);
        tick();
        applyStimulus(2'b10, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        waitGnt("t2_handover", 2'b10, 10);

        // 3: three stale RX bytes drained, requester 1 never sees them
        doReset();
        applyStimulus(2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33);
        refreshPhy();
        tick();
        applyStimulus(2'b10, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        cnt = 0; leak = 1'b0; bad = 1'b1;
        for (int i = 0; i < 30 && bad; i++) begin
            tick();
            @(negedge clk);
            if (uart_rx_fifo_rd_en) cnt++;
            if (gnt == 2'b10) bad = 1'b0;
            else if (!m_rx_empty[1]) leak = 1'b1;
        end
        checkOutput("t3_reached", {63'd0, bad}, 64'd0);
        checkOutput("t3_rd_pulses", 64'(cnt), 64'd3);
        checkOutput("t3_no_leak", {63'd0, leak}, 64'd0);

        // 4: release deferred while a double break is busy
        doReset();
        applyStimulus(2'b01, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            @(negedge clk);
            if (gnt != 2'b01) bad = 1'b1;
        end
        checkOutput("t4_held", {63'd0, bad}, 64'd0);
        tick();
        double_break_busy = 1'b0;
        @(negedge clk);
        checkOutput("t4_still", {62'd0, gnt}, 64'h1);
        tick();
        @(negedge clk);
        checkOutput("t4_drop", {62'd0, gnt}, 64'h0);

        // 5: idle owner
        doReset();
        applyStimulus(2'b01, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b01, 16'h0000, 2'b01, 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b01, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
`ifdef UPDI_ARB_WATCHDOG_EN
        firstRev = 0;
        for (int n = 1; n <= 40 && firstRev == 0; n++) begin
            tick();
            @(negedge clk);
            if (revoke[0]) firstRev = n;
        end
        checkOutput("t5_revoke_cycle", 64'(firstRev), 64'd20);
        checkOutput("t5_gnt_off", {62'd0, gnt}, 64'h0);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            @(negedge clk);
            if (gnt != 2'b00) bad = 1'b1;
        end
        checkOutput("t5_lockout", {63'd0, bad}, 64'd0);
        tick();
        req = 2'b00;
        tick();
        req = 2'b01;
        waitGnt("t5_regrant", 2'b01, 10);
`else
        firstRev = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            @(negedge clk);
            if (gnt != 2'b01 || revoke != 2'b00) firstRev = n;
        end
        checkOutput("t5_hold_no_wd", 64'(firstRev), 64'd0);
`endif

        // 6: asynchronous reset mid-GRANT drops strobes at once
        doReset();
        applyStimulus(2'b01, 16'h0077, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b01, 16'h0077, 2'b01, 2'b01, 2'b01, 1'b0);
        @(negedge clk);
        checkOutput("t6_pre_wr", {63'd0, uart_tx_fifo_wr_en}, 64'h1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_strobes", {61'd0, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en, double_break_start}, 64'd0);
        checkOutput("t6_async_gnt", {62'd0, gnt}, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("t6_tie_after_rst", {62'd0, gnt}, 64'h1);

        // Randomized traffic, with quiet stretches so the watchdog can fire
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit quiet;
            quiet = ((cyc / 150) % 3) == 2;
            for (int i = 0; i < 2; i++) if ($urandom_range(15) == 0) req[i] = ~req[i];
            m_tx_data  = 16'($urandom);
            m_tx_wr_en = (!quiet && $urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
            m_rx_rd_en = (!quiet && $urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
            m_db_start = (!quiet && $urandom_range(5) == 0) ? 2'($urandom) : 2'b00;
            if (quiet) double_break_busy = 1'b0;
            else if ($urandom_range(24) == 0) double_break_busy = ~double_break_busy;
            uart_tx_fifo_full = 1'($urandom);
            phy_error         = ($urandom_range(7) == 0);
            double_break_done = ($urandom_range(7) == 0);
            if (rxq.size() < 6 && $urandom_range(4) == 0) rxq.push_back(8'($urandom));
            refreshPhy();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
